// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the round-robin shared-adder arbiter.
// Optional signed-overflow flag is enabled with `define ADD_ARB_OVF_EN.
package add_arb_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } add_arb_state_t;

    // One-hot to binary index; supports up to 8 requesters, returns 0 for an empty vector.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) onehot_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Implemented as rotate -> priority pick -> rotate back, so no modulo arithmetic is needed.
module rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_rgnt;
    logic [NUM_REQ-1:0] w_back;
    logic               w_hit;

    always_comb begin
        w_rot  = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_rgnt = '0;
        w_hit  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_hit && w_rot[k]) begin
                w_rgnt[k] = 1'b1;
                w_hit     = 1'b1;
            end
        end
        // Undo the rotation: shifting the doubled vector right by N-ptr is a left rotate by ptr.
        w_back = NUM_REQ'({w_rgnt, w_rgnt} >> (NUM_REQ - int'(i_ptr)));
        o_gnt  = i_en ? w_back : '0;
    end

    assign o_idx = ID_W'(onehot_idx(8'(o_gnt)));
    assign o_any = |o_gnt;

endmodule

// File: rtl/add_arbiter.sv
// Shares one WIDTH-bit adder among NUM_REQ requesters with round-robin grant and a registered,
// ID-tagged result on a valid/ready channel. Define ADD_ARB_OVF_EN to add the res_ovf output.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_sum,
    output logic [ID_W-1:0]          res_id,
    input  logic                     res_ready,
`ifdef ADD_ARB_OVF_EN
    output logic                     res_ovf,
`endif
    output logic                     busy
);

    add_arb_state_t                  r_state;
    logic [ID_W-1:0]                 r_ptr;
    logic [WIDTH-1:0]                r_sum;
    logic [ID_W-1:0]                 r_id;

    logic                            w_en;
    logic                            w_any;
    logic [ID_W-1:0]                 w_gidx;
    logic [ID_W-1:0]                 w_ptr_nxt;
    logic [NUM_REQ-1:0][WIDTH-1:0]   w_a_vec;
    logic [NUM_REQ-1:0][WIDTH-1:0]   w_b_vec;
    logic [WIDTH-1:0]                w_a;
    logic [WIDTH-1:0]                w_b;
    logic [WIDTH-1:0]                w_sum;

    // Reset gates the grant so no requester sees a handshake while the block is held in reset.
    assign w_en = rst_n & ((r_state == IDLE) | res_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_en),
        .o_gnt (req_ready),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    assign w_a_vec   = req_a;
    assign w_b_vec   = req_b;
    assign w_a       = w_a_vec[w_gidx];
    assign w_b       = w_b_vec[w_gidx];
    assign w_sum     = w_a + w_b;
    assign w_ptr_nxt = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_id    <= '0;
        end else if (w_any) begin
            r_state <= BUSY;
            r_ptr   <= w_ptr_nxt;
            r_sum   <= w_sum;
            r_id    <= w_gidx;
        end else if (res_ready) begin
            r_state <= IDLE;
        end
    end

`ifdef ADD_ARB_OVF_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_any) begin
            r_ovf <= w_ovf;
        end
    end

    assign res_ovf = r_ovf;
`endif

    assign res_valid = (r_state == BUSY);
    assign busy      = (r_state == BUSY);
    assign res_sum   = r_sum;
    assign res_id    = r_id;

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized + directed bench for add_arbiter against a cycle-level behavioural model.
module tb_add_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic [W-1:0]     res_sum;
    logic [IW-1:0]    res_id;
    logic             res_ready;
    logic             busy;
`ifdef ADD_ARB_OVF_EN
    logic             res_ovf;
`endif

    int n_err = 0;
    int n_chk = 0;

    // Stimulus held by the bench and applied at the start of each step
    logic [N-1:0] s_vld;
    logic [W-1:0] s_a [N];
    logic [W-1:0] s_b [N];
    logic         s_rdy;
    logic         s_rst_n;

    // Reference model: pointer, held result, last grant
    int           m_ptr;
    bit           m_vld;
    logic [W-1:0] m_sum;
    int           m_id;
    bit           m_ovf;
    int           g_last;

    add_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready),
`ifdef ADD_ARB_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 6)
            0:       rnd_op = 32'h7FFF_FFFF;
            1:       rnd_op = 32'h8000_0000;
            2:       rnd_op = 32'hFFFF_FFFF;
            3:       rnd_op = 32'h0000_0001;
            default: rnd_op = $urandom;
        endcase
    endfunction

    // Drive inputs, check DUT against the model before the edge, advance the model across the edge.
    task automatic step();
        int     g;
        int     idx;
        longint s;
        rst_n     = s_rst_n;
        req_valid = s_vld;
        res_ready = s_rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = s_a[i];
            req_b[i*W +: W] = s_b[i];
        end
        g = -1;
        if (s_rst_n && (!m_vld || s_rdy)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && s_vld[IW'(idx)]) g = idx;
            end
        end
        #1;
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("res_valid", 64'(res_valid), 64'(m_vld));
        chk("busy", 64'(busy), 64'(m_vld));
        if (m_vld) begin
            chk("res_sum", 64'(res_sum), 64'(m_sum));
            chk("res_id", 64'(res_id), 64'(m_id));
`ifdef ADD_ARB_OVF_EN
            chk("res_ovf", 64'(res_ovf), 64'(m_ovf));
`endif
        end
        if (!s_rst_n) begin
            m_vld = 1'b0;
            m_ptr = 0;
            m_ovf = 1'b0;
        end else if (g >= 0) begin
            m_sum = s_a[IW'(g)] + s_b[IW'(g)];
            s     = longint'($signed(s_a[IW'(g)])) + longint'($signed(s_b[IW'(g)]));
            m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_id  = g;
            m_vld = 1'b1;
            m_ptr = (g + 1) % N;
        end else if (s_rdy) begin
            m_vld = 1'b0;
        end
        g_last = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt;
        bit  done;
        m_ptr = 0; m_vld = 1'b0; m_sum = '0; m_id = 0; m_ovf = 1'b0; g_last = -1;
        s_rst_n = 1'b0; s_rdy = 1'b1; s_vld = '1;
        for (int i = 0; i < N; i++) begin
            s_a[i] = W'(i);
            s_b[i] = 32'd10;
        end
        rst_n = 1'b0; req_valid = '1; res_ready = 1'b1; req_a = '0; req_b = '0;
        @(posedge clk);
        #1;

        // Reset held with all requesters valid
        step();
        step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // All requesters active: grant order 0,1,2,3,0
        s_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("aa_id", 64'(res_id), 64'(k % N));
            chk("aa_sum", 64'(res_sum), 64'(10 + k % N));
        end

        // Backpressure on a single result
        s_vld = 4'b0010; s_a[1] = 32'h7FFF_FFF0; s_b[1] = 32'd5;
        step();
        s_rdy = 1'b0; s_vld = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_sum", 64'(res_sum), 64'h7FFF_FFF5);
            chk("bp_id", 64'(res_id), 64'd1);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        s_rdy = 1'b1;
        step();

        // Wrap and overflow
        s_vld = 4'b0001; s_a[0] = 32'h7FFF_FFFF; s_b[0] = 32'd1;
        step();
        chk("wrap_sum", 64'(res_sum), 64'h8000_0000);
`ifdef ADD_ARB_OVF_EN
        chk("wrap_ovf", 64'(res_ovf), 64'd1);
`endif
        s_a[0] = 32'hFFFF_FFFF; s_b[0] = 32'd1;
        step();
        chk("neg_sum", 64'(res_sum), 64'd0);
`ifdef ADD_ARB_OVF_EN
        chk("neg_ovf", 64'(res_ovf), 64'd0);
`endif

        // Fairness: req0 always valid, req2 raised at cycle 5
        s_vld = 4'b0001; s_a[2] = 32'd7; s_b[2] = 32'd3;
        cnt = 0; done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) s_vld[2] = 1'b1;
            step();
            if (c >= 5 && !done && res_valid) begin
                cnt++;
                if (res_id == 2'd2) begin
                    done = 1'b1;
                    s_vld[2] = 1'b0;
                end
            end
        end
        chk("fair", 64'(done && cnt <= 2), 64'd1);

        // Reset while holding a result
        s_vld = 4'b0100; s_rdy = 1'b0; s_a[2] = 32'd100; s_b[2] = 32'd23;
        step();
        step();
        chk("mr_busy", 64'(res_valid), 64'd1);
        s_rst_n = 1'b0;
        step();
        chk("mr_vld", 64'(res_valid), 64'd0);
        s_rst_n = 1'b1; s_rdy = 1'b1; s_vld = 4'b1111;
        for (int i = 0; i < N; i++) begin
            s_a[i] = W'(i);
            s_b[i] = 32'd10;
        end
        step();
        chk("mr_id", 64'(res_id), 64'd0);
        chk("mr_sum", 64'(res_sum), 64'd10);

        // Randomized traffic
        s_vld = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_vld[i] && ($urandom % 3 == 0)) begin
                    s_vld[i] = 1'b1;
                    s_a[i]   = rnd_op();
                    s_b[i]   = rnd_op();
                end
            end
            s_rdy   = ($urandom % 4) != 0;
            s_rst_n = ($urandom % 100) != 0;
            step();
            if (g_last >= 0) s_vld[IW'(g_last)] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one 32-bit signed adder (out = A + B, wraps mod 2^32) between NUM_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Registers the sum, tags it with the winner's ID and presents it on a single valid/ready result channel.
- Sits between the decode/issue logic and the ALU arithmetic unit; it is the only path by which requesters reach the adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width in bits.
- ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*WIDTH  packed operand A. Requester i occupies bits [i*WIDTH +: WIDTH]. Signed.
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing as req_a. Signed.
- req_ready  output  NUM_REQ  one-hot grant. Handshake occurs on req_valid[i] & req_ready[i].
- res_valid  output  1  result valid.
- res_sum  output  WIDTH  registered A+B of the granted request.
- res_id  output  ID_W  index of the requester that produced res_sum.
- res_ready  input  1  result consumer ready.
- busy  output  1  high while a result is held (state BUSY).

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active low.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - res_valid=0, res_sum=0, res_id=0, busy=0.
  - req_ready=0 during reset.
  - Reset mid-operation discards any held result with no output pulse.
- States:
  - IDLE: no result held.
  - BUSY: result registered, res_valid=1.
- Accept condition: can_accept = (state==IDLE) | res_ready.
- Grant (combinational):
  - If can_accept and any req_valid, the winner g is the first set req_valid index at or after rr_ptr, scanning upward with wrap at NUM_REQ-1 -> 0.
  - req_ready = onehot(g). Otherwise req_ready = 0.
  - At most one req_ready bit is high in any cycle.
- On a grant (rising edge):
  - res_sum <= req_a[g] + req_b[g], truncated to WIDTH bits, two's-complement wrap, no saturation.
  - res_id <= g.
  - res_valid <= 1, state <= BUSY.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: 1 cycle from handshake to res_valid.
- Throughput: 1 result per cycle while res_ready stays high.
- BUSY with res_ready=0:
  - res_valid, res_sum and res_id are held stable. No grant is issued.
  - rr_ptr is unchanged.
- BUSY with res_ready=1:
  - If no req_valid: res_valid <= 0, state <= IDLE.
  - Otherwise: a new grant is taken in the same cycle (back-to-back), state stays BUSY.
- IDLE with no req_valid: nothing changes. rr_ptr is held.
- Requester rules:
  - Once req_valid[i] is raised, it stays high with stable operands until the handshake.
  - req_valid must not depend on req_ready. req_ready depends combinationally on req_valid and res_ready.
- Fairness: a continuously requesting source is granted within NUM_REQ grants.
- Single requester: it is granted every accept opportunity regardless of rr_ptr.
- busy == (state==BUSY) == res_valid.

Optional Feature:
- Macro: ADD_ARB_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit), registered alongside res_sum.
  - res_ovf = 1 when sign(a)==sign(b) and sign(sum)!=sign(a) (signed overflow).
  - Reset value 0; held with res_sum.
- Not defined:
  - Port res_ovf is absent.
  - res_sum behaviour is identical (silent wrap).

Decomposition:
- Package add_arb_pkg:
  - WIDTH_DEFAULT=32.
  - typedef enum logic {IDLE, BUSY} add_arb_state_t.
  - function onehot_idx for one-hot -> index.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational.
- Top level holds the state register, rr_ptr, the adder and the result registers.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, res_valid=0, res_sum=0, res_id=0, busy=0. After release, first grant goes to req 0.
- All requesters active (req_valid=4'b1111, res_ready=1, req i operands a=i, b=10) -> grant order 0,1,2,3,0. Results 10,11,12,13 with res_id 0..3 on consecutive cycles.
- Backpressure: req1 a=32'h7FFF_FFF0, b=5 with res_ready=0 for 3 cycles -> res_sum=32'h7FFF_FFF5 and res_id=1 held stable. req_ready=0 throughout. Completes the cycle res_ready=1.
- Wrap and overflow: a=32'h7FFF_FFFF, b=1 -> res_sum=32'h8000_0000. res_ovf=1 if ADD_ARB_OVF_EN is defined. a=-1, b=1 -> res_sum=0, res_ovf=0.
- Fairness: req0 held valid continuously, req2 raised at cycle 5 -> req2 granted within 2 grants of raising.
- Mid-operation reset: rst_n=0 while state=BUSY with res_valid=1 -> next cycle res_valid=0 and rr_ptr=0. The discarded result never appears.
